// File: rtl/halfband_decimator_if.sv
// Sample stream between the CIC decimator and the halfband stage, plus the FSM debug view.
// Handshake: `in` transfers on an edge where in_valid && in_ready; in_valid while !in_ready drops the word (no stall).
interface halfband_decimator_if #(
  parameter int ISZ = 31,
  parameter int OSZ = 16
);
  logic signed [ISZ-1:0] in;
  logic                  in_valid;
  logic                  in_ready;
  logic signed [OSZ-1:0] out;
  logic                  out_valid;
  logic                  overrun;
  logic [1:0]            dbg_state;

  modport master (
    output in, in_valid,
    input  in_ready, out, out_valid, overrun, dbg_state
  );

  modport slave (
    input  in, in_valid,
    output in_ready, out, out_valid, overrun, dbg_state
  );
endinterface

// File: rtl/halfband_decimator.sv
// Decimate-by-2 11-tap halfband FIR, serial symmetric MAC with one multiplier.
// Define HALFBAND_SAT_EN to clamp the output; otherwise the rounded result wraps to OSZ bits.
module halfband_decimator #(
  parameter int ISZ   = 31,
  parameter int OSZ   = 16,
  parameter int CSZ   = 18,
  parameter int NTAPS = 11
) (
  input logic                 in_clk,
  input logic                 reset,
  halfband_decimator_if.slave bus
);
  localparam int ASZ = ISZ + CSZ + 3;
  localparam int RSZ = ASZ - 32;
  localparam logic [1:0] K_LAST = 2'd2;
  localparam logic signed [ASZ-1:0] RND = {{(ASZ-32){1'b0}}, 1'b1, 31'b0};

  typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, OUT = 2'd2} state_t;

  state_t                state;
  logic signed [ISZ-1:0] x [NTAPS];
  logic                  phase;
  logic [1:0]            k;
  logic signed [ASZ-1:0] acc;
  logic signed [OSZ-1:0] out_q;
  logic                  out_valid_q;
  logic                  overrun_q;
  logic                  ready;

  logic signed [ISZ-1:0]     tap_a, tap_b;
  logic signed [CSZ-1:0]     coef;
  logic signed [ISZ:0]       pre_add;
  logic signed [ISZ+CSZ:0]   prod;
  logic signed [ASZ-1:0]     prod_ext, centre_ext, acc_rnd;
  logic signed [RSZ-1:0]     res;
  logic signed [OSZ-1:0]     out_next;
  logic                      unused_bits;

  assign ready = (state == IDLE);

  // Symmetric pair and its shared coefficient for MAC step k.
  always_comb begin
    tap_a = x[0];
    tap_b = x[NTAPS-1];
    coef  = 18'sd1024;
    case (k)
      2'd0: begin tap_a = x[0]; tap_b = x[NTAPS-1]; coef = 18'sd1024;  end
      2'd1: begin tap_a = x[2]; tap_b = x[NTAPS-3]; coef = -18'sd6656; end
      default: begin tap_a = x[4]; tap_b = x[NTAPS-5]; coef = 18'sd38400; end
    endcase
  end

  assign pre_add    = {tap_a[ISZ-1], tap_a} + {tap_b[ISZ-1], tap_b};
  assign prod       = pre_add * coef;
  assign prod_ext   = {{(ASZ-ISZ-CSZ-1){prod[ISZ+CSZ]}}, prod};
  // Centre coefficient is exactly 2^16, so it enters as a shift, not a multiply.
  assign centre_ext = {{(ASZ-ISZ-16){x[(NTAPS-1)/2][ISZ-1]}}, x[(NTAPS-1)/2], 16'b0};
  assign acc_rnd    = acc + RND;
  assign res        = acc_rnd[ASZ-1:32];

`ifdef HALFBAND_SAT_EN
  localparam logic signed [RSZ-1:0] OUT_MAX = {{(RSZ-OSZ+1){1'b0}}, {(OSZ-1){1'b1}}};
  localparam logic signed [RSZ-1:0] OUT_MIN = {{(RSZ-OSZ+1){1'b1}}, {(OSZ-1){1'b0}}};
  always_comb begin
    out_next = res[OSZ-1:0];
    if (res > OUT_MAX)      out_next = OUT_MAX[OSZ-1:0];
    else if (res < OUT_MIN) out_next = OUT_MIN[OSZ-1:0];
  end
  assign unused_bits = ^acc_rnd[31:0];
`else
  assign out_next    = res[OSZ-1:0];
  assign unused_bits = ^{acc_rnd[31:0], res[RSZ-1:OSZ]};
`endif

  always_ff @(posedge in_clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NTAPS; i++) x[i] <= '0;
      state       <= IDLE;
      phase       <= 1'b0;
      k           <= 2'd0;
      acc         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (bus.in_valid && !ready) overrun_q <= 1'b1;
      case (state)
        IDLE: begin
          if (bus.in_valid) begin
            x[0] <= bus.in;
            for (int i = 1; i < NTAPS; i++) x[i] <= x[i-1];
            phase <= ~phase;
            // phase is 1 after odd-numbered accepts, so this is the 2nd, 4th, ... sample.
            if (phase) begin
              state <= MAC;
              k     <= 2'd0;
            end
          end
        end
        MAC: begin
          acc <= ((k == 2'd0) ? centre_ext : acc) + prod_ext;
          if (k == K_LAST) state <= OUT;
          else             k     <= k + 2'd1;
        end
        OUT: begin
          out_q       <= out_next;
          out_valid_q <= 1'b1;
          state       <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = ready;
  assign bus.out       = out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.dbg_state = state;
endmodule

// File: tb/tb_halfband_decimator.sv
// Directed bench for halfband_decimator: impulses, DC, saturation, overrun and reset abort.
module tb_halfband_decimator;
  localparam int ISZ = 31;
  localparam int OSZ = 16;
  localparam logic signed [ISZ-1:0] IMP    = 31'sd1048576;
  localparam logic signed [ISZ-1:0] POS_FS = {1'b0, {(ISZ-1){1'b1}}};
  localparam logic signed [ISZ-1:0] NEG_FS = {1'b1, {(ISZ-1){1'b0}}};
`ifdef HALFBAND_SAT_EN
  localparam int POS_EXP = 32767;
`else
  localparam int POS_EXP = -32768;
`endif

  // clock / reset
  logic in_clk = 1'b0;
  logic reset  = 1'b0;
  always #5 in_clk = ~in_clk;

  halfband_decimator_if #(.ISZ(ISZ), .OSZ(OSZ)) bus ();
  halfband_decimator #(.ISZ(ISZ), .OSZ(OSZ), .CSZ(18), .NTAPS(11)) dut (
    .in_clk(in_clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  logic signed [OSZ-1:0] obs_q[$];
  int obs_cyc_q[$];

  always @(posedge in_clk) cyc <= cyc + 1;

  always @(negedge in_clk) begin
    if (bus.out_valid === 1'b1) begin
      obs_q.push_back(bus.out);
      obs_cyc_q.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // driver tasks
  task automatic send(input logic signed [ISZ-1:0] v, input int idle);
    @(negedge in_clk);
    check("in_ready", bus.in_ready, 1);
    bus.in       = v;
    bus.in_valid = 1'b1;
    @(posedge in_clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in       = '0;
    last_acc     = cyc;
    repeat (idle) @(posedge in_clk);
  endtask

  task automatic expect_none(input string tag);
    check(tag, obs_q.size(), 0);
  endtask

  task automatic expect_out(input string tag, input logic signed [63:0] exp);
    logic signed [OSZ-1:0] v;
    int c;
    check({tag, "_count"}, obs_q.size(), 1);
    if (obs_q.size() > 0) begin
      v = obs_q.pop_front();
      c = obs_cyc_q.pop_front();
      check(tag, v, exp);
      check({tag, "_lat"}, c - last_acc, 4);
    end
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  task automatic pair(input logic signed [ISZ-1:0] a, input logic signed [ISZ-1:0] b,
                      input string tag, input bit chk, input logic signed [63:0] exp);
    send(a, 31);
    expect_none({tag, "_nontrig"});
    send(b, 31);
    if (chk) expect_out(tag, exp);
    else begin
      obs_q.delete();
      obs_cyc_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge in_clk);
    reset = 1'b0;
    repeat (3) @(negedge in_clk);
    check("rst_out", bus.out, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_overrun", bus.overrun, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_state", bus.dbg_state, 0);
    reset = 1'b1;
    obs_q.delete();
    obs_cyc_q.delete();
  endtask

  initial begin
    bus.in       = '0;
    bus.in_valid = 1'b0;

    // impulse on the trigger sample
    do_reset();
    pair('0, IMP, "imp_t0", 1'b1, 0);
    pair('0, '0, "imp_t1", 1'b1, -2);
    pair('0, '0, "imp_t2", 1'b1, 9);
    pair('0, '0, "imp_t3", 1'b1, 9);
    pair('0, '0, "imp_t4", 1'b1, -2);
    pair('0, '0, "imp_t5", 1'b1, 0);
    pair('0, '0, "imp_t6", 1'b1, 0);

    // impulse on the non-trigger sample
    do_reset();
    pair(IMP, '0, "imp_n0", 1'b1, 0);
    pair('0, '0, "imp_n1", 1'b1, 0);
    pair('0, '0, "imp_n2", 1'b1, 16);
    pair('0, '0, "imp_n3", 1'b1, 0);
    pair('0, '0, "imp_n4", 1'b1, 0);
    pair('0, '0, "imp_n5", 1'b1, 0);

    // DC step: partial sums of the coefficient set, then unity gain
    do_reset();
    pair(IMP, IMP, "dc0", 1'b1, 0);
    pair(IMP, IMP, "dc1", 1'b1, -1);
    pair(IMP, IMP, "dc2", 1'b1, 24);
    pair(IMP, IMP, "dc3", 1'b1, 33);
    pair(IMP, IMP, "dc4", 1'b1, 32);
    pair(IMP, IMP, "dc5", 1'b1, 32);
    pair(IMP, IMP, "dc6", 1'b1, 32);

    // positive full scale: rounds to 32768
    do_reset();
    for (int i = 0; i < 5; i++) pair(POS_FS, POS_FS, "sat_pos_fill", 1'b0, 0);
    pair(POS_FS, POS_FS, "sat_pos0", 1'b1, POS_EXP);
    pair(POS_FS, POS_FS, "sat_pos1", 1'b1, POS_EXP);

    // negative full scale: exactly -32768
    do_reset();
    for (int i = 0; i < 5; i++) pair(NEG_FS, NEG_FS, "sat_neg_fill", 1'b0, 0);
    pair(NEG_FS, NEG_FS, "sat_neg0", 1'b1, -32768);
    pair(NEG_FS, NEG_FS, "sat_neg1", 1'b1, -32768);

    // overrun: a sample offered during MAC is dropped
    do_reset();
    send('0, 31);
    expect_none("ovr_nontrig");
    send(IMP, 1);
    @(negedge in_clk);
    check("ovr_in_ready", bus.in_ready, 0);
    bus.in       = IMP;
    bus.in_valid = 1'b1;
    @(posedge in_clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in       = '0;
    check("ovr_flag", bus.overrun, 1);
    repeat (30) @(posedge in_clk);
    expect_out("ovr0", 0);
    pair('0, '0, "ovr1", 1'b1, -2);
    pair('0, '0, "ovr2", 1'b1, 9);
    pair('0, '0, "ovr3", 1'b1, 9);
    pair('0, '0, "ovr4", 1'b1, -2);
    pair('0, '0, "ovr5", 1'b1, 0);
    check("ovr_sticky", bus.overrun, 1);

    // reset one cycle into MAC
    do_reset();
    send('0, 31);
    @(negedge in_clk);
    bus.in       = IMP;
    bus.in_valid = 1'b1;
    @(posedge in_clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in       = '0;
    @(posedge in_clk);
    #1;
    check("mid_state_mac", bus.dbg_state, 1);
    reset = 1'b0;
    #1;
    check("mid_state_idle", bus.dbg_state, 0);
    check("mid_in_ready", bus.in_ready, 1);
    repeat (5) @(posedge in_clk);
    @(negedge in_clk);
    reset = 1'b1;
    repeat (10) @(posedge in_clk);
    expect_none("mid_no_out");
    check("mid_out", bus.out, 0);
    check("mid_overrun", bus.overrun, 0);
    check("mid_ready_after", bus.in_ready, 1);
    send(IMP, 31);
    expect_none("mid_phase0");
    send(IMP, 31);
    expect_out("mid_after", 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
